// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: frame geometry, line idle level and the transmitter
// state encoding used by uart_tx_fifo.
package uart_tx_fifo_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered occupancy count and registered full/empty
// flags. The head entry is always visible on dout.
module fifo_sync #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  push, pop;

  // A write while full is dropped even when a pop happens on the same edge.
  assign push = wr && !full;
  assign pop  = rd && !empty;
  assign dout = mem[rd_ptr];

  always_comb begin
    // NOTE: default assigned first so every path drives count_next; no latch.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in fifo_sync and are shifted out
// LSB first, back-to-back, with the bit time set by an internal divider.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DIV        = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       out
);

  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state, state_next;
  logic [DIV_W-1:0]          div_cnt, div_next;
  logic [2:0]                bit_idx, bit_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next, fifo_dout;
  logic                      pop, out_next, busy_next;

  fifo_sync #(
    .WIDTH      (UART_DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .din   (din),
    .rd    (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          div_next   = DIV_LAST;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (div_cnt == '0) begin
          bit_next   = '0;
          div_next   = DIV_LAST;
          state_next = ST_DATA;
        end else begin
          div_next = div_cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (div_cnt == '0) begin
          shift_next = {1'b0, shift[UART_DATA_BITS-1:1]};
          div_next   = DIV_LAST;
          if (bit_idx == BIT_LAST) state_next = ST_STOP;
          else                     bit_next   = bit_idx + 1'b1;
        end else begin
          div_next = div_cnt - 1'b1;
        end
      end
      ST_STOP: begin
        // The next start bit follows the stop bit directly when data is waiting.
        if (div_cnt == '0) begin
          div_next = DIV_LAST;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          div_next = div_cnt - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line level and busy are decoded from the next state so both come from flops.
  always_comb begin
    busy_next = (state_next != ST_IDLE);
    case (state_next)
      ST_START: out_next = 1'b0;
      ST_DATA:  out_next = shift_next[0];
      default:  out_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      out     <= UART_IDLE_LEVEL;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      out     <= out_next;
      busy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame tables, multi-cycle corner
// sequences and random bursts decoded by a behavioural serial receiver.
module tb_uart_tx_fifo;

  localparam int DIV        = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] din;
  logic       full, empty, busy, out;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DIV(DIV), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .din   (din),
    .full  (full),
    .empty (empty),
    .busy  (busy),
    .out   (out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural receiver: finds a falling edge, samples mid-bit, LSB first.
  logic [7:0] rx_q [$];
  int         rx_ferr = 0;

  initial begin
    logic [7:0] b;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (out === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        if (out === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = out;
          end
          repeat (DIV) @(negedge clk);
          stop_bit = out;
          if (stop_bit === 1'b1) rx_q.push_back(b);
          else                   rx_ferr++;
        end
      end
    end
  end

  int rd_idx = 0;

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < rd_idx + n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("rx_wait", 32'(rx_q.size() >= rd_idx + n), 32'd1);
  endtask

  task automatic expect_rx(input string name, input logic [7:0] exp);
    if (rx_q.size() > rd_idx) begin
      check(name, 32'(rx_q[rd_idx]), 32'(exp));
      rd_idx++;
    end else begin
      check(name, 32'hxxxx_xxxx, 32'(exp));
    end
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((busy || !empty) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_wait", 32'(!busy && empty), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    wr  = 1'b1;
    din = d;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  vec_t       vecs [6];
  logic [7:0] exp_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cap;
    logic [7:0] d;
    int         busy_cnt, runs, ferr_base, n;
    logic       prev_busy;

    vecs[0] = '{8'hA9, frame_of(8'hA9)};
    vecs[1] = '{8'h00, frame_of(8'h00)};
    vecs[2] = '{8'hFF, frame_of(8'hFF)};
    vecs[3] = '{8'h55, frame_of(8'h55)};
    vecs[4] = '{8'h80, frame_of(8'h80)};
    vecs[5] = '{8'h01, frame_of(8'h01)};

    // Reset held for four cycles, then released.
    reset = 1'b1;
    wr    = 1'b0;
    din   = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_out", 32'(out), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_rel", 32'(out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    repeat (20) @(negedge clk);
    check("rst_no_rx", 32'(rx_q.size()), 32'd0);

    // Single-byte frames from the table: latency, bit pattern, exact length.
    for (int i = 0; i < 6; i++) begin
      push_byte(vecs[i].data);
      check($sformatf("v%0d_empty_after_wr", i), 32'(empty), 32'd0);
      check($sformatf("v%0d_out_after_wr", i), 32'(out), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_out_start", i), 32'(out), 32'd0);
      check($sformatf("v%0d_busy_start", i), 32'(busy), 32'd1);
      check($sformatf("v%0d_empty_pop", i), 32'(empty), 32'd1);
      repeat (DIV / 2) @(negedge clk);
      cap[0] = out;
      for (int k = 1; k < 10; k++) begin
        repeat (DIV) @(negedge clk);
        cap[k] = out;
      end
      check($sformatf("v%0d_frame", i), 32'(cap), 32'(vecs[i].frame));
      repeat (DIV / 2 - 1) @(negedge clk);
      check($sformatf("v%0d_busy_last", i), 32'(busy), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_out_end", i), 32'(out), 32'd1);
      wait_rx(1, 200);
      expect_rx($sformatf("v%0d_rx", i), vecs[i].data);
    end

    // Burst of three bytes on consecutive cycles: one contiguous busy run.
    busy_cnt  = 0;
    runs      = 0;
    prev_busy = 1'b0;
    @(negedge clk);
    wr = 1'b1;
    foreach (vecs[i]) if (i < 0) wr = 1'b0;
    din = 8'h99;
    @(negedge clk);
    if (busy && !prev_busy) runs++;
    busy_cnt += int'(busy); prev_busy = busy;
    din = 8'hB1;
    @(negedge clk);
    if (busy && !prev_busy) runs++;
    busy_cnt += int'(busy); prev_busy = busy;
    din = 8'hEA;
    @(negedge clk);
    if (busy && !prev_busy) runs++;
    busy_cnt += int'(busy); prev_busy = busy;
    wr = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) runs++;
      busy_cnt += int'(busy);
      prev_busy = busy;
    end
    check("burst_busy_cycles", 32'(busy_cnt), 32'd240);
    check("burst_busy_runs", 32'(runs), 32'd1);
    wait_rx(3, 300);
    expect_rx("burst_rx0", 8'h99);
    expect_rx("burst_rx1", 8'hB1);
    expect_rx("burst_rx2", 8'hEA);

    // Seventeen writes fill the FIFO; a write while full is dropped.
    wait_idle(1000);
    @(negedge clk);
    wr = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      din = 8'(i);
      @(negedge clk);
    end
    check("fill_full", 32'(full), 32'd1);
    din = 8'hFF;
    @(negedge clk);
    wr = 1'b0;
    check("fill_full_after_drop", 32'(full), 32'd1);
    wait_rx(DEPTH + 1, (DEPTH + 2) * 10 * DIV);
    for (int i = 0; i <= DEPTH; i++) expect_rx($sformatf("fill_rx%0d", i), 8'(i));
    wait_idle(2000);
    repeat (100) @(negedge clk);
    check("fill_no_extra", 32'(rx_q.size()), 32'(rd_idx));
    check("fill_full_clear", 32'(full), 32'd0);

    // Random bursts that never exceed the FIFO, checked against a queue model.
    for (int r = 0; r < 6; r++) begin
      wait_idle(2000);
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        exp_q.push_back(d);
        push_byte(d);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_rx(exp_q.size(), (exp_q.size() + 2) * 10 * DIV);
    while (exp_q.size() > 0) expect_rx("rand_rx", exp_q.pop_front());
    wait_idle(2000);
    check("no_framing_errors", 32'(rx_ferr), 32'd0);

    // Reset in the middle of a data bit with three bytes still queued.
    push_byte(8'h55);
    @(negedge clk);
    wr = 1'b1;
    din = 8'hAA;
    @(negedge clk);
    din = 8'hBB;
    @(negedge clk);
    din = 8'hCC;
    @(negedge clk);
    wr = 1'b0;
    repeat (36) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_out", 32'(out), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (120) @(negedge clk);
    rd_idx    = rx_q.size();
    ferr_base = rx_ferr;
    check("post_rst_idle", 32'({busy, empty, out}), 32'b011);
    push_byte(8'h3C);
    wait_rx(1, 200);
    expect_rx("post_rst_rx", 8'h3C);
    repeat (100) @(negedge clk);
    check("post_rst_no_extra", 32'(rx_q.size()), 32'(rd_idx));

    // Write lands exactly on the final stop-bit cycle of the previous frame.
    wait_idle(1000);
    push_byte(8'h5A);
    @(negedge clk);
    repeat (10 * DIV - 1) @(negedge clk);
    check("last_stop_busy", 32'(busy), 32'd1);
    check("last_stop_out", 32'(out), 32'd1);
    wr  = 1'b1;
    din = 8'hC3;
    @(negedge clk);
    wr = 1'b0;
    check("gap_busy", 32'(busy), 32'd0);
    check("gap_empty", 32'(empty), 32'd0);
    @(negedge clk);
    check("gap_restart_out", 32'(out), 32'd0);
    check("gap_restart_busy", 32'(busy), 32'd1);
    wait_rx(2, 300);
    expect_rx("gap_rx0", 8'h5A);
    expect_rx("gap_rx1", 8'hC3);
    check("post_rst_ferr", 32'(rx_ferr - ferr_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
